// File: rtl/vec5_pkg.sv
// Shared constants and helpers for the five-input pairwise-match tracker.
package vec5_pkg;

  localparam int N_IN = 5;
  localparam int MATCH_W = 25;
  localparam logic [MATCH_W-1:0] ALL_ONES = 25'h1FFFFFF;
  // Diagonal positions (x_i against itself): bits 24, 18, 12, 6, 0.
  localparam logic [MATCH_W-1:0] DIAG_MASK = 25'h1041041;

  // Occupancy of the single-entry result register.
  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_FULL  = 1'b1
  } occ_t;

  // Bit position in the match vector for the pair (x_i, x_j).
  function automatic logic [4:0] pair_idx(input int i, input int j);
    return 5'(24 - 5 * i - j);
  endfunction

endpackage

// File: rtl/vec5_popcount25.sv
// Combinational population count of a 25-bit vector.
module vec5_popcount25
  import vec5_pkg::*;
(
  input  logic [MATCH_W-1:0] bits,
  output logic [4:0]         count
);

  // Sum all bits; 25 fits in 5 bits, so the count never wraps.
  always_comb begin
    count = 5'd0;
    for (int k = 0; k < MATCH_W; k++) begin
      count = count + 5'(bits[k]);
    end
  end

endmodule

// File: rtl/vec5_match_tracker.sv
// Consumes pairwise-XNOR match vectors: registers popcount, all-agree and
// consistency-error flags per sample, tracks a run of all-agree samples and
// raises a sticky lock when the run reaches THRESH.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. Upstream may not rely on in_ready before asserting in_valid; the
// result register holds its fields stable while out_valid && !out_ready.
module vec5_match_tracker
  import vec5_pkg::*;
#(
  parameter int RUN_W  = 8,
  parameter int THRESH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MATCH_W-1:0] match,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_pop,
  output logic               out_all_eq,
  output logic               out_err,
  output logic [RUN_W-1:0]   out_run,
  output logic               lock,
  input  logic               clr_lock
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_THRESH = RUN_W'(THRESH);

  occ_t             occ;
  logic [4:0]       pop_q;
  logic             all_eq_q;
  logic             err_q;
  logic [RUN_W-1:0] run_q;
  logic             lock_q;

  logic [4:0]       pop;
  logic             all_eq;
  logic             err;
  logic [RUN_W-1:0] run_next;
  logic             accept;
  logic             handshake;
  logic             lock_set;

  vec5_popcount25 u_pop (
    .bits  (match),
    .count (pop)
  );

  // Accept / handshake qualifiers; the slot frees up in the same cycle it drains.
  always_comb begin
    in_ready  = resetn && ((occ == OCC_EMPTY) || out_ready);
    accept    = in_valid && in_ready;
    handshake = (occ == OCC_FULL) && out_ready;
  end

  // Consistency check: diagonal must be all ones and the matrix symmetric.
  always_comb begin
    err = ((match & DIAG_MASK) != DIAG_MASK);
    for (int i = 0; i < N_IN; i++) begin
      for (int j = i + 1; j < N_IN; j++) begin
        if (match[pair_idx(i, j)] != match[pair_idx(j, i)]) begin
          err = 1'b1;
        end
      end
    end
  end

  // Next run value (saturating) and the lock set condition for this sample.
  always_comb begin
    all_eq = (match == ALL_ONES);
    if (!all_eq) begin
      run_next = '0;
    end else if (run_q == RUN_MAX) begin
      run_next = RUN_MAX;
    end else begin
      run_next = run_q + 1'b1;
    end
    lock_set = accept && (run_next >= RUN_THRESH);
  end

  // Result register and occupancy; run counter advances only on accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      occ      <= OCC_EMPTY;
      pop_q    <= '0;
      all_eq_q <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= '0;
    end else if (accept) begin
      occ      <= OCC_FULL;
      pop_q    <= pop;
      all_eq_q <= all_eq;
      err_q    <= err;
      run_q    <= run_next;
    end else if (handshake) begin
      occ      <= OCC_EMPTY;
    end
  end

  // Sticky lock: a set event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q <= 1'b0;
    end else if (lock_set) begin
      lock_q <= 1'b1;
    end else if (clr_lock) begin
      lock_q <= 1'b0;
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid  = (occ == OCC_FULL);
    out_pop    = pop_q;
    out_all_eq = all_eq_q;
    out_err    = err_q;
    out_run    = run_q;
    lock       = lock_q;
  end

endmodule

// File: tb/tb_vec5_match_tracker.sv
// Directed and randomized bench for vec5_match_tracker with a result scoreboard.
module tb_vec5_match_tracker;

  localparam int RUN_W  = 8;
  localparam int THRESH = 4;
  localparam logic [24:0] ONES = 25'h1FFFFFF;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [24:0]       match = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4:0]        out_pop;
  logic              out_all_eq;
  logic              out_err;
  logic [RUN_W-1:0]  out_run;
  logic              lock;
  logic              clr_lock = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state and expected result queue {pop, all_eq, err, run}.
  logic [14:0]      exp_q[$];
  logic             m_valid = 1'b0;
  logic [RUN_W-1:0] m_run = '0;
  logic             m_lock = 1'b0;

  vec5_match_tracker #(.RUN_W(RUN_W), .THRESH(THRESH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .match      (match),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pop    (out_pop),
    .out_all_eq (out_all_eq),
    .out_err    (out_err),
    .out_run    (out_run),
    .lock       (lock),
    .clr_lock   (clr_lock)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Match vector built from five input bits: bit (24-5i-j) = ~(xi ^ xj).
  function automatic logic [24:0] vec_from(input logic [4:0] x);
    logic [24:0] v;
    v = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        v[24 - 5 * i - j] = ~(x[4 - i] ^ x[4 - j]);
    return v;
  endfunction

  function automatic logic model_err(input logic [24:0] m);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!m[24 - 6 * i]) e = 1'b1;
      for (int j = i + 1; j < 5; j++)
        if (m[24 - 5 * i - j] != m[24 - 5 * j - i]) e = 1'b1;
    end
    return e;
  endfunction

  // One clock: check observable state at the negedge, advance the model, cross the edge.
  task automatic step();
    logic exp_rdy, acc, hs, set, ae, er;
    logic [4:0] pc;
    @(negedge clk);
    exp_rdy = resetn && (!m_valid || out_ready);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_valid);
    check("lock", lock, m_lock);
    if (m_valid && exp_q.size() > 0)
      check("out_fields", {out_pop, out_all_eq, out_err, out_run}, exp_q[0]);
    if (!resetn) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_run = '0;
      m_lock = 1'b0;
    end else begin
      acc = in_valid && exp_rdy;
      hs = m_valid && out_ready;
      set = 1'b0;
      if (hs) void'(exp_q.pop_front());
      if (acc) begin
        ae = (match == ONES);
        er = model_err(match);
        pc = 5'($countones(match));
        if (!ae) m_run = '0;
        else if (m_run != 8'hFF) m_run = m_run + 1'b1;
        set = (int'(m_run) >= THRESH);
        exp_q.push_back({pc, ae, er, m_run});
      end
      m_valid = acc ? 1'b1 : (hs ? 1'b0 : m_valid);
      m_lock = set ? 1'b1 : (clr_lock ? 1'b0 : m_lock);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [24:0] m);
    in_valid = 1'b1;
    match = m;
    step();
  endtask

  initial begin
    // Reset
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_pop", out_pop, 0);
    check("rst_run", out_run, 0);
    check("rst_lock", lock, 0);
    check("rst_flags", {out_all_eq, out_err}, 0);
    resetn = 1'b1;
    out_ready = 1'b1;

    // Four all-agree samples: run 1..4, lock on the 4th
    for (int k = 1; k <= 4; k++) begin
      send(ONES);
      check("run_count", out_run, k);
      check("pop25", out_pop, 25);
      check("lock_rise", lock, (k >= 4) ? 1 : 0);
    end

    // a=1,b=0,c=d=e=1
    check("vec_build", vec_from(5'b10111), 25'h1745EF7);
    send(25'h1745EF7);
    check("pop17", out_pop, 17);
    check("flags17", {out_all_eq, out_err}, 0);
    check("run_reset", out_run, 0);
    check("lock_held", lock, 1);

    // Clear lock, build run to 3, then a diagonal fault
    in_valid = 1'b0;
    clr_lock = 1'b1;
    step();
    clr_lock = 1'b0;
    check("lock_clr", lock, 0);
    repeat (3) send(ONES);
    check("run3", out_run, 3);
    send(25'h1FFFFFE);
    check("diag_err", out_err, 1);
    check("diag_pop", out_pop, 24);
    check("diag_run", out_run, 0);
    check("diag_lock", lock, 0);
    send(25'h17FFFFF);
    check("asym_err", out_err, 1);

    // Backpressure: hold for 3 cycles with a new sample waiting
    send(25'h1745EF7);
    out_ready = 1'b0;
    match = 25'h0000001;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ready", in_ready, 0);
      check("bp_hold", out_pop, 17);
    end
    out_ready = 1'b1;
    step();
    check("bp_valid", out_valid, 1);
    check("bp_new", out_pop, 1);

    // Set and clear on the same edge: set wins
    repeat (3) send(ONES);
    clr_lock = 1'b1;
    send(ONES);
    check("set_wins", lock, 1);
    in_valid = 1'b0;
    step();
    clr_lock = 1'b0;
    check("clr_alone", lock, 0);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_lock = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: match = ONES;
        1: match = vec_from(5'($urandom_range(0, 31)));
        default: match = 25'($urandom) & ONES;
      endcase
      step();
    end
    clr_lock = 1'b0;
    out_ready = 1'b1;

    // Saturation
    repeat (300) send(ONES);
    check("run_sat", out_run, 255);

    // Mid-stream reset with a result held
    resetn = 1'b0;
    step();
    check("mid_valid", out_valid, 0);
    check("mid_fields", {out_pop, out_all_eq, out_err, out_run}, 0);
    check("mid_lock", lock, 0);
    resetn = 1'b1;
    send(ONES);
    check("run_restart", out_run, 1);

    // Drain
    in_valid = 1'b0;
    repeat (2) step();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec5_match_tracker.md
Name: vec5_match_tracker

Overview:
- Downstream consumer of the 25-bit pairwise-XNOR match vector produced from inputs a..e.
- Index mapping: x0=a … x4=e; bit (24-5i-j) = ~(xi ^ xj).
- Per accepted sample, registers the match popcount, an all-agree flag and a consistency-error flag.
- Tracks a saturating run of consecutive all-agree samples and raises a sticky lock once the run reaches a threshold.
- Single-entry output register with valid/ready handshake on both sides.

Parameters:
- RUN_W, 8: width of the consecutive-agree run counter.
- THRESH, 4: run length at which lock asserts; legal range 1..2^RUN_W-1.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- in_valid  input  1  match sample valid
- in_ready  output  1  block can accept a sample
- match  input  25  pairwise-XNOR vector, bit mapping as in Overview
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  downstream accepts result
- out_pop  output  5  number of ones in the accepted match (0..25)
- out_all_eq  output  1  accepted match == 25'h1FFFFFF
- out_err  output  1  accepted match inconsistent (see Behaviour)
- out_run  output  RUN_W  run count after this sample
- lock  output  1  sticky: run reached THRESH
- clr_lock  input  1  clears lock

Behaviour:
- Reset: single clock domain, clk. Reset is synchronous, active-low (resetn sampled on the rising clk edge).
  - While resetn=0: out_valid, out_pop, out_all_eq, out_err, out_run, lock, internal run counter all 0; in_ready=0.
  - Reset mid-transfer discards the held result, no residue.
- Accept rule:
  - in_ready = resetn && (!out_valid || out_ready), combinational.
  - Sample accepted on a clk edge with in_valid && in_ready.
- Latency: 1 cycle. Result fields load on the accept edge; out_valid=1 the next cycle.
- Throughput: one sample per cycle when out_ready=1.
- Output hold: out_* fields stable while out_valid && !out_ready. out_valid drops after a handshake edge with no simultaneous accept.
- Error check (combinational on match): out_err=1 if either condition holds.
  - Any diagonal bit (24,18,12,6,0) is 0.
  - Any pair bit(24-5i-j) != bit(24-5j-i) for i<j.
- all_eq = (match == 25'h1FFFFFF); implies err=0.
- Run counter, updated only on accept:
  - all_eq=1: run <= run+1, saturating at 2^RUN_W-1.
  - Otherwise (including err): run <= 0.
  - out_run carries the new value.
- Lock:
  - Set on the accept edge where the new run >= THRESH.
  - Cleared on an edge with clr_lock=1 and no set event.
  - Set and clear in the same cycle: set wins.
  - lock is a status output, independent of the out handshake.
- Popcount: full 25-bit count, zero-extended into 5 bits, no wrap.
- No FSM beyond the out_valid state.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on handshake without accept.
  - FULL -> FULL on handshake with accept, or when stalled.

Decomposition:
- Package vec5_pkg holds:
  - constants N_IN=5, MATCH_W=25, ALL_ONES=25'h1FFFFFF, DIAG_MASK=25'h1041041;
  - function pair_idx(i,j) = 24-5i-j.
- Sub-module vec5_popcount25: purely combinational, 25-bit in -> 5-bit count.
- Error check and run/lock logic stay in the top.

Test Plan:
- Four cycles of match=25'h1FFFFFF, out_ready=1, THRESH=4 -> out_pop=25, out_all_eq=1, out_run 1,2,3,4; lock rises on the edge loading run=4.
- a=1,b=0,c=d=e=1 gives match=25'h1745EF7 -> out_pop=17, out_all_eq=0, out_err=0, out_run=0, lock unchanged.
- match=25'h1FFFFFE (diagonal bit 0 cleared) after run=3 -> out_err=1, out_pop=24, out_run=0, lock stays 0.
- match=25'h17FFFFF (bit 23 only; pair (0,1) asymmetric) -> out_err=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid held and a new match -> in_ready=0, out_* unchanged.
  - Then out_ready=1 -> same-edge handshake plus accept; out_valid stays 1 with the new fields; no sample lost or duplicated.
- clr_lock=1 on the same edge as the 4th consecutive all-agree accept -> lock=1.
  - clr_lock alone next cycle -> lock=0.
- 300 consecutive all-agree samples -> out_run saturates at 255.
- resetn=0 for one cycle mid-stream with out_valid=1 -> all outputs 0 next cycle; run restarts at 1 on the next all-agree sample.
